strobe_burst_gen: RTL

Produces a burst of N single-cycle enable strobes spaced by a programmable number of clock cycles, then flags completion. It is the transmitting end of the enable-strobe interface: its `strobe` output drives the `enput` input of the game's strobe-counting blocks. In the memory-sequence game it paces sequence playback, for example one LED step per strobe.

---
 rtl/game_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/strobe_burst_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the memory-sequence game blocks.
package game_pkg;

    localparam int PERIOD_W_DEF = 16;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } burst_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Loadable down-counter that sets the spacing between strobes.
// `pre_zero` flags the cycle before the count reaches zero, so the parent can register its strobe.
module tick_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero,
    output logic         pre_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero     = (cnt == '0);
    assign pre_zero = (cnt == W'(1));

endmodule

// File: rtl/strobe_burst_gen.sv
// Issues a burst of N single-cycle strobes spaced P cycles apart, then pulses done.
// All outputs are registered; strobe is set one edge early from the prescaler lookahead.
module strobe_burst_gen
    import game_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period,
    input  logic [CNT_W-1:0]    count,
    output logic                strobe,
    output logic                busy,
    output logic                done
);

    burst_state_t        state;
    logic [PERIOD_W-1:0] p_q;
    logic [CNT_W-1:0]    remaining;
    logic [PERIOD_W-1:0] p_eff;
    logic                accept, last;
    logic                pre_load, pre_en, pre_zero_now, pre_one;
    logic [PERIOD_W-1:0] pre_val;

    assign p_eff  = (period == '0) ? PERIOD_W'(1) : period;
    assign accept = (state != RUN) && start && !abort;
    assign last   = (remaining == CNT_W'(1));

    // Reload only between strobes; the final strobe leaves the prescaler idle.
    assign pre_load = accept || (state == RUN && !abort && pre_zero_now && !last);
    assign pre_val  = accept ? p_eff - 1'b1 : p_q - 1'b1;
    assign pre_en   = (state == RUN) && !abort;

    tick_prescaler #(.W(PERIOD_W)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load),
        .load_val (pre_val),
        .en       (pre_en),
        .zero     (pre_zero_now),
        .pre_zero (pre_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            p_q       <= '0;
            remaining <= '0;
            strobe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            strobe <= 1'b0;
            done   <= 1'b0;
            case (state)
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pre_zero_now) begin
                        // This is a strobe cycle: count it off, chain the next one.
                        remaining <= remaining - 1'b1;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            strobe <= (p_q == PERIOD_W'(1));
                        end
                    end else begin
                        strobe <= pre_one;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (accept) begin
                        p_q       <= p_eff;
                        remaining <= count;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            strobe <= (p_eff == PERIOD_W'(1));
                        end
                    end
                end
            endcase
        end
    end

endmodule
